// File: rtl/level_controller_if.sv
// Signal bundle between the level controller and the rest of the whack-a-mole game.
// The controller sits on the master side; the player/display side uses the slave modport.
interface level_controller_if;
    logic        start;
    logic [7:0]  score;
    logic        game;
    logic [27:0] speed;
    logic [2:0]  level;
    logic [6:0]  time_left;
    logic        game_over;
    logic [7:0]  final_score;
    logic        level_up;

    modport master (
        input  start, score,
        output game, speed, level, time_left, game_over, final_score, level_up
    );

    modport slave (
        output start, score,
        input  game, speed, level, time_left, game_over, final_score, level_up
    );
endinterface

// File: rtl/level_controller.sv
// Game-level FSM: round countdown, score-driven level-ups that shrink the mole window,
// and final score capture at game over. Every output comes straight from a register.
module level_controller #(
    parameter int unsigned CLK_HZ           = 50000000,
    parameter int unsigned ROUND_SECONDS    = 60,
    parameter int unsigned BASE_SPEED       = 99999999,
    parameter int unsigned SPEED_STEP       = 12500000,
    parameter int unsigned MIN_SPEED        = 24999999,
    parameter int unsigned POINTS_PER_LEVEL = 5,
    parameter int unsigned MAX_LEVEL        = 7
) (
    input logic                clock,
    input logic                reset,
    level_controller_if.master bus
);
    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST   = PW'(CLK_HZ - 1);
    localparam logic [6:0]    ROUND_INIT   = 7'(ROUND_SECONDS);
    localparam logic [27:0]   SPEED_INIT   = 28'(BASE_SPEED);
    localparam logic [27:0]   SPEED_DEC    = 28'(SPEED_STEP);
    localparam logic [27:0]   SPEED_FLOOR  = 28'(MIN_SPEED);
    localparam logic [27:0]   SPEED_CLAMP  = 28'(MIN_SPEED + SPEED_STEP);
    localparam logic [8:0]    THRESH_STEP  = 9'(POINTS_PER_LEVEL);
    localparam logic [2:0]    LEVEL_TOP    = 3'(MAX_LEVEL);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StPlay     = 2'd1;
    localparam logic [1:0] StLevelUp  = 2'd2;
    localparam logic [1:0] StGameOver = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    time_q, time_d;
    logic [2:0]    level_q, level_d;
    logic [27:0]   speed_q, speed_d;
    logic [8:0]    thresh_q, thresh_d;
    logic [7:0]    final_q, final_d;
    logic          game_q, game_d;
    logic          over_q, over_d;
    logic          lu_q, lu_d;

    logic running, tick, expire, reload;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        time_d   = time_q;
        level_d  = level_q;
        speed_d  = speed_q;
        thresh_d = thresh_q;
        final_d  = final_q;
        lu_d     = 1'b0;
        reload   = 1'b0;

        running = (state_q == StPlay) || (state_q == StLevelUp);
        tick    = running && (presc_q == PRESC_LAST);
        expire  = tick && (time_q <= 7'd1);

        case (state_q)
            StIdle: begin
                reload = 1'b1;
                if (bus.start) state_d = StPlay;
            end
            StPlay, StLevelUp: begin
                if (!bus.start) begin
                    state_d = StIdle;
                    reload  = 1'b1;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) time_d = time_q - 7'd1;
                    // Expiry pre-empts both a pending increment and a fresh threshold crossing.
                    if (expire) begin
                        state_d = StGameOver;
                        final_d = bus.score;
                    end else if (state_q == StLevelUp) begin
                        state_d  = StPlay;
                        level_d  = level_q + 3'd1;
                        thresh_d = thresh_q + THRESH_STEP;
                        speed_d  = (speed_q >= SPEED_CLAMP) ? speed_q - SPEED_DEC : SPEED_FLOOR;
                        lu_d     = 1'b1;
                    end else if (({1'b0, bus.score} >= thresh_q) && (level_q < LEVEL_TOP)) begin
                        state_d = StLevelUp;
                    end
                end
            end
            StGameOver: begin
                if (!bus.start) begin
                    state_d = StIdle;
                    reload  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (reload) begin
            presc_d  = '0;
            time_d   = ROUND_INIT;
            level_d  = 3'd1;
            speed_d  = SPEED_INIT;
            thresh_d = THRESH_STEP;
        end

        game_d = (state_d == StPlay) || (state_d == StLevelUp);
        over_d = (state_d == StGameOver);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            time_q   <= ROUND_INIT;
            level_q  <= 3'd1;
            speed_q  <= SPEED_INIT;
            thresh_q <= THRESH_STEP;
            final_q  <= 8'd0;
            game_q   <= 1'b0;
            over_q   <= 1'b0;
            lu_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            time_q   <= time_d;
            level_q  <= level_d;
            speed_q  <= speed_d;
            thresh_q <= thresh_d;
            final_q  <= final_d;
            game_q   <= game_d;
            over_q   <= over_d;
            lu_q     <= lu_d;
        end
    end

    assign bus.game        = game_q;
    assign bus.speed       = speed_q;
    assign bus.level       = level_q;
    assign bus.time_left   = time_q;
    assign bus.game_over   = over_q;
    assign bus.final_score = final_q;
    assign bus.level_up    = lu_q;
endmodule

// File: tb/tb_level_controller.sv
// Scoreboard bench for level_controller with a 10-cycle second and a 3-second round.
module tb_level_controller;
    localparam int unsigned B = 99999999;
    localparam int unsigned S = 12500000;

    typedef struct {
        string      tag;
        logic [48:0] v;
    } exp_t;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;
    int   pulses;
    exp_t sb[$];

    level_controller_if bus ();

    level_controller #(
        .CLK_HZ          (10),
        .ROUND_SECONDS   (3),
        .BASE_SPEED      (99999999),
        .SPEED_STEP      (12500000),
        .MIN_SPEED       (24999999),
        .POINTS_PER_LEVEL(5),
        .MAX_LEVEL       (7)
    ) dut (
        .clock(clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [48:0] pack_out(logic g, logic go, logic lu, logic [2:0] l,
                                             logic [6:0] t, logic [7:0] f, logic [27:0] s);
        return {g, go, lu, l, t, f, s};
    endfunction

    task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Fields: game, game_over, level_up, level, time_left, final_score, speed.
    task automatic exp_out(string tag, int g, int go, int lu, int l, int t, int f, int unsigned s);
        exp_t e;
        e.tag = tag;
        e.v   = pack_out(g[0], go[0], lu[0], 3'(l), 7'(t), 8'(f), 28'(s));
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        logic [48:0] obs;
        @(posedge clk);
        #1;
        obs = pack_out(bus.game, bus.game_over, bus.level_up, bus.level, bus.time_left,
                       bus.final_score, bus.speed);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, {15'd0, obs}, {15'd0, e.v});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.score = 8'd0;
        repeat (2) step();
        exp_out("reset", 0, 0, 0, 1, 3, 0, B);
        step();
        reset = 1'b0;
        exp_out("play_entry", 1, 0, 0, 1, 3, 0, B);
        step();

        // Full round with no score: one second per 10 cycles, expiry on cycle 30.
        for (int k = 1; k <= 30; k++) begin
            if (k == 30) exp_out("expire", 0, 1, 0, 1, 0, 0, B);
            else         exp_out("countdown", 1, 0, 0, 1, (k < 10) ? 3 : (k < 20) ? 2 : 1, 0, B);
            step();
        end
        bus.start = 1'b0;
        exp_out("over_to_idle", 0, 0, 0, 1, 3, 0, B);
        step();

        // Threshold crossed on the expiry tick: game over wins, level stays 1.
        bus.start = 1'b1;
        bus.score = 8'd4;
        exp_out("coll_start", 1, 0, 0, 1, 3, 0, B);
        step();
        repeat (29) step();
        bus.score = 8'd7;
        exp_out("collide", 0, 1, 0, 1, 0, 7, B);
        step();
        bus.start = 1'b0;
        exp_out("coll_idle", 0, 0, 0, 1, 3, 7, B);
        step();

        // Single level-up, then score drop, then abort.
        bus.start = 1'b1;
        bus.score = 8'd4;
        exp_out("lu_start", 1, 0, 0, 1, 3, 7, B);
        step();
        repeat (2) begin
            exp_out("lu_below", 1, 0, 0, 1, 3, 7, B);
            step();
        end
        bus.score = 8'd5;
        exp_out("lu_enter", 1, 0, 0, 1, 3, 7, B);
        step();
        exp_out("lu_pulse", 1, 0, 1, 2, 3, 7, B - S);
        step();
        exp_out("lu_after", 1, 0, 0, 2, 3, 7, B - S);
        step();
        bus.score = 8'd4;
        exp_out("lu_drop", 1, 0, 0, 2, 3, 7, B - S);
        step();
        bus.start = 1'b0;
        exp_out("abort", 0, 0, 0, 1, 3, 7, B);
        step();

        // Chained level-ups to saturation, crossing a tick while in LEVEL_UP.
        bus.start = 1'b1;
        bus.score = 8'd40;
        exp_out("chain_start", 1, 0, 0, 1, 3, 7, B);
        step();
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            int lvl;
            lvl = 1 + (((k / 2) < 6) ? (k / 2) : 6);
            exp_out("chain", 1, 0, ((k % 2 == 0) && (k <= 12)) ? 1 : 0, lvl, (k < 10) ? 3 : 2,
                    7, B - S * (lvl - 1));
            step();
            pulses += int'(bus.level_up);
        end
        check_eq("chain_pulses", 64'(pulses), 64'd6);

        // Reset in the middle of a round at level 3.
        bus.start = 1'b0;
        exp_out("pre_mid_idle", 0, 0, 0, 1, 3, 7, B);
        step();
        bus.start = 1'b1;
        bus.score = 8'd10;
        exp_out("mid_e0", 1, 0, 0, 1, 3, 7, B);
        step();
        exp_out("mid_e1", 1, 0, 0, 1, 3, 7, B);
        step();
        exp_out("mid_e2", 1, 0, 1, 2, 3, 7, B - S);
        step();
        exp_out("mid_e3", 1, 0, 0, 2, 3, 7, B - S);
        step();
        exp_out("mid_e4", 1, 0, 1, 3, 3, 7, B - 2 * S);
        step();
        exp_out("mid_e5", 1, 0, 0, 3, 3, 7, B - 2 * S);
        step();
        reset = 1'b1;
        exp_out("rst_mid", 0, 0, 0, 1, 3, 0, B);
        step();
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/level_controller.md
Name: level_controller

Overview:
Game-level FSM for the whack-a-mole design. It drives the `game` enable and the 28-bit mole-visible window `speed` into display_controller and player. It consumes the live score from player, raises the level at fixed score thresholds, shortening the window each time. It runs a per-round countdown and latches the final score at game over.

Parameters:
CLK_HZ, 50000000, clock cycles per one-second tick
ROUND_SECONDS, 60, round length in seconds (1..127)
BASE_SPEED, 99999999, speed at level 1 (2 s window at 50 MHz)
SPEED_STEP, 12500000, speed decrement per level-up
MIN_SPEED, 24999999, speed floor
POINTS_PER_LEVEL, 5, score points per level threshold
MAX_LEVEL, 7, highest level (<=7)

Ports:
clock  input  1  system clock (CLOCK_50)
reset  input  1  synchronous, active-high reset
start  input  1  game switch level (SW[0]); high = play requested
score  input  8  live score from player
game  output  1  high only in PLAY and LEVEL_UP; feeds display_controller and player
speed  output  28  mole window in cycles; feeds display_controller
level  output  3  current level, 1..MAX_LEVEL
time_left  output  7  seconds remaining in round
game_over  output  1  high in GAME_OVER
final_score  output  8  score captured on entry to GAME_OVER
level_up  output  1  one-cycle pulse on each level increment

Behaviour:
- Reset, in every state, gives: state IDLE, game=0, speed=BASE_SPEED, level=1, time_left=ROUND_SECONDS, game_over=0, final_score=0, level_up=0. The prescaler is 0 and threshold=POINTS_PER_LEVEL.
- Priority is reset > abort (start=0 in PLAY/LEVEL_UP) > timer expiry > level-up.
- The threshold register is 9 bits wide. It is compared against zero-extended score. No multiplier is used.
- The prescaler counts 0..CLK_HZ-1 and runs only in PLAY and LEVEL_UP. A tick occurs on the cycle it equals CLK_HZ-1; it then wraps to 0.
- All outputs are registered. Every transition takes effect at the output one cycle after the deciding edge.
- IDLE:
  - game=0.
  - time_left, level, speed, threshold and prescaler hold reset values; final_score holds its last value.
  - start=1 moves to PLAY.
- PLAY:
  - game=1.
  - On a tick with time_left>1, time_left decrements.
  - On a tick with time_left==1, time_left becomes 0, final_score captures score that cycle, and the FSM moves to GAME_OVER.
  - If score>=threshold and level<MAX_LEVEL (and there is no expiry or abort), the FSM moves to LEVEL_UP.
  - start=0 aborts to IDLE and reloads all counters. final_score is NOT updated.
- LEVEL_UP (exactly one cycle, game stays 1):
  - level+1; threshold+POINTS_PER_LEVEL; level_up=1.
  - speed = max(speed-SPEED_STEP, MIN_SPEED). Compare before subtracting so there is no underflow.
  - Timer continues.
  - Return to PLAY. If the score is still >= the new threshold, PLAY re-enters LEVEL_UP on the next cycle, so each pass adds one level.
  - A tick landing in LEVEL_UP is applied there, including expiry. Expiry wins and goes to GAME_OVER without the increment.
- GAME_OVER:
  - game=0, game_over=1.
  - final_score, level and speed hold.
  - start=0 moves to IDLE (reset counters, game_over=0). The player must toggle the switch to replay.
- Score may decrease (wrong button). Level and speed never decrease within a round.
- At level==MAX_LEVEL, thresholds are ignored and the FSM stays in PLAY.

Test Plan:
- Use CLK_HZ=10 and ROUND_SECONDS=3 for all scenarios.
- Reset with start=1 → first cycle after reset release: IDLE, game=0, level=1, speed=99999999, time_left=3. Next cycle: game=1.
- Expiry: start=1, score=0 → time_left steps 3→2→1 every 10 cycles. On the 30th tick-cycle: game=0, game_over=1, final_score=0. Then start=0 → IDLE with time_left=3.
- Level-up: in PLAY, drive score 4 then 5 → one level_up pulse, level=2, speed=87499999. Score back to 4 → level stays 2.
- Chained/saturation: jump score to 40 → six consecutive level_up pulses. level=7, speed=24999999 (floor). No further pulses.
- Abort and collision: start=0 mid-round → game=0 next cycle, game_over=0, final_score unchanged. Separately, score crosses threshold on the expiry tick → GAME_OVER, level unchanged.
- Reset mid-round (PLAY, level 3) → all outputs return to reset values next cycle. final_score=0.
